packet_trigger_gen: RTL and testbench
=====================================

// Module: packet_trigger_gen
// PURPOSE
//  Upstream stage of the gated backscatter clock divider. Watches the envelope-detector output for an
//  incoming excitation packet, qualifies it, waits a fixed offset, then raises trigger_signal for a
//  fixed window. trigger_signal feeds the divider's trigger_signal input; divider runs only while high.
//  Holdoff plus envelope-low re-arm gives one trigger per packet.
// PARAMETERS
//  SYNC_STAGES    2     synchronizer flops on envelope_in (>=2)
//  QUAL_CYCLES    64    consecutive synced-high cycles required to accept a packet (>=1)
//  DELAY_CYCLES   1024  cycles from qualification to trigger assertion (>=1)
//  ACTIVE_CYCLES  8192  cycles trigger_signal stays high (>=1)
//  HOLDOFF_CYCLES 4096  minimum dead time after the active window (>=1)
//  CNT_W          16    shared down/up counter width; must hold max(param)-1
// PORTS
//  clock_in       in   1      system clock, same domain as the divider
//  reset          in   1      synchronous, active-high reset
//  enable         in   1      arm; low forces IDLE
//  envelope_in    in   1      asynchronous envelope-detector comparator output
//  trigger_signal out  1      registered; high during ACTIVE window
//  busy           out  1      registered; high in any state other than IDLE
//  trig_count     out  8      registered count of ACTIVE entries, wraps 255->0
// BEHAVIOUR
//  - Reset (sampled on rising clock_in): state=IDLE; cnt=0; sync chain=0; env_prev=0;
//    trigger_signal=0; busy=0; trig_count=0. A reset in any state, including mid-ACTIVE,
//    drops trigger_signal on that edge.
//  - env_s = last synchronizer stage; env_prev = env_s delayed by 1 cycle.
//  - FSM (cnt cleared on every state change):
//    IDLE:    enable & env_s & !env_prev -> QUALIFY.
//    QUALIFY: !env_s -> IDLE; else cnt==QUAL_CYCLES-1 -> DELAY; else cnt++.
//    DELAY:   cnt==DELAY_CYCLES-1 -> ACTIVE (trig_count++); else cnt++. Envelope ignored.
//    ACTIVE:  cnt==ACTIVE_CYCLES-1 -> HOLDOFF; else cnt++.
//    HOLDOFF: cnt saturates at HOLDOFF_CYCLES-1. Exit to IDLE only when saturated and env_s==0.
//             An envelope still high keeps the block in HOLDOFF; re-arm then needs a fresh rising edge.
//  - enable==0 in any state -> IDLE on that edge; trigger_signal=0 on that edge; trig_count unchanged.
//  - trigger_signal is a flop set on the edge entering ACTIVE and cleared on the edge leaving it.
//    It is high for exactly ACTIVE_CYCLES cycles.
//  - Latency: envelope_in high before edge k and held -> trigger_signal rises at edge
//    k+SYNC_STAGES+QUAL_CYCLES+DELAY_CYCLES (defaults: k+1090).
//  - A glitch shorter than QUAL_CYCLES synced cycles never triggers.
//  - Simultaneous enable fall and ACTIVE entry: enable wins, no trigger, no count.
// CONFIGURATION
//  TRIG_ABORT_EN defined: in ACTIVE, env_s==0 -> HOLDOFF on that edge (trigger ends early).
//                         trig_count still reflects the entry.
//  TRIG_ABORT_EN undefined: ACTIVE always runs the full ACTIVE_CYCLES regardless of envelope.
// STRUCTURE
//  packet_trigger_pkg (shared include): state encodings ST_IDLE=0, ST_QUALIFY=1, ST_DELAY=2,
//  ST_ACTIVE=3, ST_HOLDOFF=4 (3-bit), and the parameter default localparams.
//  One sub-module, env_sync: SYNC_STAGES-deep flop chain with synchronous active-high reset.
//  FSM, counter and outputs live in packet_trigger_gen.
// TESTING (defaults unless noted)
//  1. envelope_in high at edge 10, held 20000 cycles -> trigger rises at edge 1100, high 8192 cycles;
//     trig_count=1; busy falls once holdoff is done and envelope is low.
//  2. envelope_in pulse 40 cycles -> state returns IDLE; trigger_signal never high; trig_count=0.
//  3. Envelope held high through holdoff -> no second trigger. Envelope low, then high again ->
//     second trigger, trig_count=2.
//  4. reset asserted mid-ACTIVE -> trigger_signal, busy, trig_count all 0 after that edge;
//     enable dropped mid-DELAY -> IDLE next edge, no trigger.
//  5. TRIG_ABORT_EN defined, envelope drops 100 cycles into ACTIVE -> trigger low after
//     100+SYNC_STAGES cycles; undefined -> full 8192.
//  6. 256 packets (small params) -> trig_count wraps to 0.

Source files
------------

// File: rtl/packet_trigger_gen_pkg.sv
// Shared state encodings and parameter defaults for the packet trigger generator.
// Pure declarations: no latency, no backpressure.
package packet_trigger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUALIFY = 3'd1,
    ST_DELAY   = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  localparam int SYNC_STAGES_DEF    = 2;
  localparam int QUAL_CYCLES_DEF    = 64;
  localparam int DELAY_CYCLES_DEF   = 1024;
  localparam int ACTIVE_CYCLES_DEF  = 8192;
  localparam int HOLDOFF_CYCLES_DEF = 4096;
  localparam int CNT_W_DEF          = 16;

endpackage

// File: rtl/packet_trigger_gen_if.sv
// Control/status bundle between the trigger generator (slave) and its driver (master).
// Wires only: no latency, no backpressure.
interface packet_trigger_gen_if;

  logic       enable;
  logic       envelope_in;
  logic       trigger_signal;
  logic       busy;
  logic [7:0] trig_count;

  modport master (
    output enable,
    output envelope_in,
    input  trigger_signal,
    input  busy,
    input  trig_count
  );

  modport slave (
    input  enable,
    input  envelope_in,
    output trigger_signal,
    output busy,
    output trig_count
  );

endinterface

// File: rtl/packet_trigger_gen_env_sync.sv
// Flop-chain synchronizer bringing the asynchronous envelope comparator into clock_in.
// Latency STAGES edges; no backpressure.
module env_sync #(
  parameter int STAGES = 2
) (
  input  logic clock_in,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/packet_trigger_gen.sv
// Qualifies an envelope packet, waits a fixed offset, then drives a trigger window (TRIG_ABORT_EN: window ends on envelope loss).
// Trigger rises SYNC_STAGES+QUAL_CYCLES+DELAY_CYCLES edges after envelope rises; no backpressure, all outputs registered.
module packet_trigger_gen
  import packet_trigger_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int QUAL_CYCLES    = QUAL_CYCLES_DEF,
  parameter int DELAY_CYCLES   = DELAY_CYCLES_DEF,
  parameter int ACTIVE_CYCLES  = ACTIVE_CYCLES_DEF,
  parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input logic             clock_in,
  input logic             reset,
  packet_trigger_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] QUAL_LAST    = CNT_W'(QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LAST  = CNT_W'(ACTIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             env_s;
  logic             env_prev;
  logic             trig_inc;

  env_sync #(
    .STAGES (SYNC_STAGES)
  ) u_env_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .async_in (bus.envelope_in),
    .sync_out (env_s)
  );

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state              <= ST_IDLE;
      cnt                <= '0;
      env_prev           <= 1'b0;
      bus.trigger_signal <= 1'b0;
      bus.busy           <= 1'b0;
      bus.trig_count     <= 8'd0;
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      env_prev           <= env_s;
      bus.trigger_signal <= (state_nxt == ST_ACTIVE);
      bus.busy           <= (state_nxt != ST_IDLE);
      bus.trig_count     <= bus.trig_count + 8'(trig_inc);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    trig_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (env_s && !env_prev) begin
          state_nxt = ST_QUALIFY;
        end
      end
      ST_QUALIFY: begin
        if (!env_s) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == QUAL_LAST) begin
          state_nxt = ST_DELAY;
          cnt_nxt   = '0;
        end
      end
      ST_DELAY: begin
        if (cnt == DELAY_LAST) begin
          state_nxt = ST_ACTIVE;
          cnt_nxt   = '0;
          trig_inc  = 1'b1;
        end
      end
      ST_ACTIVE: begin
`ifdef TRIG_ABORT_EN
        if (!env_s || cnt == ACTIVE_LAST) begin
`else
        if (cnt == ACTIVE_LAST) begin
`endif
          state_nxt = ST_HOLDOFF;
          cnt_nxt   = '0;
        end
      end
      ST_HOLDOFF: begin
        // Counter parks at its terminal value until the envelope has gone away.
        if (cnt == HOLDOFF_LAST) begin
          cnt_nxt = cnt;
          if (!env_s) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Disarm has priority over every transition, including ACTIVE entry.
    if (!bus.enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      trig_inc  = 1'b0;
    end
  end

endmodule

// File: tb/tb_packet_trigger_gen.sv
// Directed bench: default-parameter instance for timing checks, small-parameter instance for wrap/coincidence.
module tb_packet_trigger_gen;

  logic clock_in = 1'b0;
  logic reset;
  logic reset_s;
  int   tests = 0;
  int   fails = 0;
  int   d_rises = 0;
  int   s_rises = 0;
  logic d_prev = 1'b0;
  logic s_prev = 1'b0;

  always #5 clock_in = ~clock_in;

  packet_trigger_gen_if d_if ();
  packet_trigger_gen_if s_if ();

  packet_trigger_gen dut (
    .clock_in (clock_in),
    .reset    (reset),
    .bus      (d_if)
  );

  packet_trigger_gen #(
    .SYNC_STAGES    (2),
    .QUAL_CYCLES    (2),
    .DELAY_CYCLES   (2),
    .ACTIVE_CYCLES  (2),
    .HOLDOFF_CYCLES (2),
    .CNT_W          (4)
  ) dut_s (
    .clock_in (clock_in),
    .reset    (reset_s),
    .bus      (s_if)
  );

  always @(negedge clock_in) begin
    if (d_if.trigger_signal === 1'b1 && d_prev !== 1'b1) d_rises++;
    d_prev = d_if.trigger_signal;
    if (s_if.trigger_signal === 1'b1 && s_prev !== 1'b1) s_rises++;
    s_prev = s_if.trigger_signal;
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  // Counts negedges until trigger_signal reaches lvl (bounded by max).
  task automatic wait_trig(input logic lvl, input int max, output int n);
    n = 0;
    do begin
      @(negedge clock_in);
      n++;
    end while (d_if.trigger_signal !== lvl && n < max);
  endtask

  task automatic do_reset();
    @(negedge clock_in);
    reset            = 1'b1;
    d_if.enable      = 1'b1;
    d_if.envelope_in = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    @(negedge clock_in);
    reset            = 1'b1;
    d_if.enable      = 1'b1;
    d_if.envelope_in = 1'b1;
    tick(3);
    tests++;
    if (d_if.trigger_signal !== 1'b0) begin
      fails++; $display("FAIL reset_trigger: got %b expected 0", d_if.trigger_signal);
    end
    tests++;
    if (d_if.busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy: got %b expected 0", d_if.busy);
    end
    tests++;
    if (d_if.trig_count !== 8'd0) begin
      fails++; $display("FAIL reset_count: got %0d expected 0", d_if.trig_count);
    end
    d_if.envelope_in = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single_packet();
    int n;
    int w;
    int base;
    do_reset();
    base = d_rises;
    d_if.envelope_in = 1'b1;
    wait_trig(1'b1, 2000, n);
    tests++;
    if (n != 1091) begin
      fails++; $display("FAIL latency: got %0d edges expected 1091", n);
    end
    tests++;
    if (d_if.trig_count !== 8'd1) begin
      fails++; $display("FAIL count_first: got %0d expected 1", d_if.trig_count);
    end
    wait_trig(1'b0, 9000, w);
    tests++;
    if (w != 8192) begin
      fails++; $display("FAIL width: got %0d expected 8192", w);
    end
    tick(20000 - n - w);
    tests++;
    if (d_if.busy !== 1'b1) begin
      fails++; $display("FAIL busy_holdoff: got %b expected 1", d_if.busy);
    end
    d_if.envelope_in = 1'b0;
    n = 0;
    do begin
      @(negedge clock_in);
      n++;
    end while (d_if.busy !== 1'b0 && n < 50);
    tests++;
    if (n != 3) begin
      fails++; $display("FAIL busy_release: got %0d edges expected 3", n);
    end
    tests++;
    if (d_rises - base != 1) begin
      fails++; $display("FAIL single_rises: got %0d expected 1", d_rises - base);
    end
  endtask

  task automatic test_glitch();
    int base;
    do_reset();
    base = d_rises;
    d_if.envelope_in = 1'b1;
    tick(5);
    tests++;
    if (d_if.busy !== 1'b1) begin
      fails++; $display("FAIL glitch_qualify: got busy %b expected 1", d_if.busy);
    end
    tick(35);
    d_if.envelope_in = 1'b0;
    tick(200);
    tests++;
    if (d_if.busy !== 1'b0) begin
      fails++; $display("FAIL glitch_idle: got busy %b expected 0", d_if.busy);
    end
    tests++;
    if (d_rises - base != 0 || d_if.trig_count !== 8'd0) begin
      fails++; $display("FAIL glitch_trig: got rises %0d count %0d expected 0 0", d_rises - base, d_if.trig_count);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int base;
    do_reset();
    base = d_rises;
    d_if.envelope_in = 1'b1;
    wait_trig(1'b1, 2000, n);
    wait_trig(1'b0, 9000, n);
    tick(4096 + 200);
    tests++;
    if (d_if.busy !== 1'b1 || d_rises - base != 1 || d_if.trig_count !== 8'd1) begin
      fails++; $display("FAIL held_no_retrig: got busy %b rises %0d count %0d expected 1 1 1", d_if.busy, d_rises - base, d_if.trig_count);
    end
    d_if.envelope_in = 1'b0;
    tick(10);
    tests++;
    if (d_if.busy !== 1'b0) begin
      fails++; $display("FAIL rearm_idle: got busy %b expected 0", d_if.busy);
    end
    d_if.envelope_in = 1'b1;
    wait_trig(1'b1, 2000, n);
    tests++;
    if (n != 1091) begin
      fails++; $display("FAIL second_latency: got %0d expected 1091", n);
    end
    tests++;
    if (d_if.trig_count !== 8'd2) begin
      fails++; $display("FAIL count_second: got %0d expected 2", d_if.trig_count);
    end
  endtask

  task automatic test_reset_enable();
    int n;
    int base;
    do_reset();
    d_if.envelope_in = 1'b1;
    wait_trig(1'b1, 2000, n);
    tick(50);
    reset = 1'b1;
    tick(1);
    tests++;
    if (d_if.trigger_signal !== 1'b0 || d_if.busy !== 1'b0 || d_if.trig_count !== 8'd0) begin
      fails++; $display("FAIL reset_active: got trig %b busy %b count %0d expected 0 0 0", d_if.trigger_signal, d_if.busy, d_if.trig_count);
    end
    reset = 1'b0;
    base = d_rises;
    tick(200);
    tests++;
    if (d_if.busy !== 1'b1) begin
      fails++; $display("FAIL delay_busy: got %b expected 1", d_if.busy);
    end
    d_if.enable = 1'b0;
    tick(1);
    tests++;
    if (d_if.busy !== 1'b0 || d_if.trigger_signal !== 1'b0) begin
      fails++; $display("FAIL disable_idle: got busy %b trig %b expected 0 0", d_if.busy, d_if.trigger_signal);
    end
    tick(1200);
    tests++;
    if (d_rises - base != 0 || d_if.trig_count !== 8'd0) begin
      fails++; $display("FAIL disable_no_trig: got rises %0d count %0d expected 0 0", d_rises - base, d_if.trig_count);
    end
  endtask

  task automatic test_abort();
    int n;
    int total;
    int exp_total;
`ifdef TRIG_ABORT_EN
    exp_total = 102;
`else
    exp_total = 8192;
`endif
    do_reset();
    d_if.envelope_in = 1'b1;
    wait_trig(1'b1, 2000, n);
    tick(99);
    d_if.envelope_in = 1'b0;
    wait_trig(1'b0, 9000, n);
    total = 99 + n;
    tests++;
    if (total != exp_total) begin
      fails++; $display("FAIL abort_width: got %0d expected %0d", total, exp_total);
    end
    tests++;
    if (d_if.trig_count !== 8'd1) begin
      fails++; $display("FAIL abort_count: got %0d expected 1", d_if.trig_count);
    end
  endtask

  task automatic test_wrap();
    int base;
    @(negedge clock_in);
    reset_s          = 1'b1;
    s_if.enable      = 1'b1;
    s_if.envelope_in = 1'b0;
    tick(2);
    reset_s = 1'b0;
    tick(1);
    base = s_rises;
    // Disarm lands on the very edge that would enter ACTIVE.
    s_if.envelope_in = 1'b1;
    tick(6);
    tests++;
    if (s_if.busy !== 1'b1) begin
      fails++; $display("FAIL small_delay_busy: got %b expected 1", s_if.busy);
    end
    s_if.enable = 1'b0;
    tick(1);
    tests++;
    if (s_if.trigger_signal !== 1'b0 || s_if.trig_count !== 8'd0 || s_if.busy !== 1'b0) begin
      fails++; $display("FAIL enable_wins: got trig %b count %0d busy %b expected 0 0 0", s_if.trigger_signal, s_if.trig_count, s_if.busy);
    end
    s_if.envelope_in = 1'b0;
    tick(4);
    s_if.enable = 1'b1;
    tick(2);
    for (int p = 0; p < 256; p++) begin
      s_if.envelope_in = 1'b1;
      tick(12);
      s_if.envelope_in = 1'b0;
      tick(8);
      if (p == 254) begin
        tests++;
        if (s_if.trig_count !== 8'd255) begin
          fails++; $display("FAIL count_255: got %0d expected 255", s_if.trig_count);
        end
      end
    end
    tests++;
    if (s_if.trig_count !== 8'd0) begin
      fails++; $display("FAIL count_wrap: got %0d expected 0", s_if.trig_count);
    end
    tests++;
    if (s_rises - base != 256) begin
      fails++; $display("FAIL wrap_rises: got %0d expected 256", s_rises - base);
    end
  endtask

  initial begin
    reset            = 1'b1;
    reset_s          = 1'b1;
    d_if.enable      = 1'b0;
    d_if.envelope_in = 1'b0;
    s_if.enable      = 1'b0;
    s_if.envelope_in = 1'b0;
    test_reset();
    test_single_packet();
    test_glitch();
    test_back_to_back();
    test_reset_enable();
    test_abort();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
